// File: rtl/branch_resolver_pkg.sv
// Shared types for the branch resolver: FSM state, queued prediction entry
// and instruction size.
package br_pkg;

    localparam int unsigned INSTR_BYTES = 4;
    // Entry fields are sized here, so the resolver's XLEN must equal BR_XLEN.
    localparam int unsigned BR_XLEN     = 32;

    typedef enum logic {
        RUN,
        FLUSH
    } br_state_t;

    typedef struct packed {
        logic [BR_XLEN-1:0] pc;
        logic               prediction;
        logic [BR_XLEN-1:0] predicted_pc;
    } br_entry_t;

endpackage

// File: rtl/branch_resolver_if.sv
// Fetch/execute-facing bundle of the branch resolver. The master side is
// the pipeline that pushes predictions and resolves branches; slave is the resolver.
interface branch_resolver_if #(
    parameter int unsigned XLEN = 32
);
    logic            pred_valid;
    logic [XLEN-1:0] pred_pc;
    logic            prediction;
    logic [XLEN-1:0] predicted_pc;
    logic            pred_ready;

    logic            ex_valid;
    logic            ex_taken;
    logic [XLEN-1:0] ex_target;
    logic            ex_ready;

    logic            upd_valid;
    logic [XLEN-1:0] upd_pc;
    logic            branch_taken;
    logic [XLEN-1:0] branch_target;

    logic            flush;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output pred_valid, pred_pc, prediction, predicted_pc,
        output ex_valid, ex_taken, ex_target,
        input  pred_ready, ex_ready,
        input  upd_valid, upd_pc, branch_taken, branch_target,
        input  flush, redirect_pc
    );

    modport slave (
        input  pred_valid, pred_pc, prediction, predicted_pc,
        input  ex_valid, ex_taken, ex_target,
        output pred_ready, ex_ready,
        output upd_valid, upd_pc, branch_taken, branch_target,
        output flush, redirect_pc
    );
endinterface

// File: rtl/branch_resolver_fifo.sv
// In-flight prediction queue: synchronous FIFO with a clear input and
// full/empty flags. DEPTH must be a power of two.
module br_pred_fifo
    import br_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter type entry_t = br_entry_t
) (
    input  logic   clk,
    input  logic   reset,
    input  logic   clear,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t head,
    output logic   full,
    output logic   empty
);
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_COUNT = (AW+1)'(DEPTH);

    entry_t        mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [AW:0]   count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == FULL_COUNT);
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/branch_resolver.sv
// Execute-stage branch resolver: checks queued predictions against actual
// outcomes, trains the predictor and flushes on mispredict. Optional
// branch/mispredict counters are built when BR_STATS_EN is defined.
module branch_resolver
    import br_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = BR_XLEN
) (
    input  logic                    clk,
    input  logic                    reset,
    branch_resolver_if.slave        bus
`ifdef BR_STATS_EN
    ,
    output logic [15:0]             branch_count,
    output logic [15:0]             mispredict_count
`endif
);
    br_state_t       state_q;
    br_state_t       state_d;
    br_entry_t       push_entry;
    br_entry_t       head;
    logic            full;
    logic            empty;
    logic            push;
    logic            pop;
    logic            miscompare;
    logic            mispredict;
    logic            fifo_push;
    logic [XLEN-1:0] actual_next_pc;

    always_comb begin
        push_entry              = '0;
        push_entry.pc           = bus.pred_pc;
        push_entry.prediction   = bus.prediction;
        push_entry.predicted_pc = bus.predicted_pc;
    end

    // A correct not-taken prediction never looks at predicted_pc.
    assign miscompare = (head.prediction != bus.ex_taken) ||
                        (head.prediction && bus.ex_taken &&
                         (head.predicted_pc != bus.ex_target));

    assign actual_next_pc = bus.ex_taken ? bus.ex_target
                                         : head.pc + XLEN'(INSTR_BYTES);

    always_comb begin
        state_d        = state_q;
        bus.pred_ready = 1'b0;
        bus.ex_ready   = 1'b0;
        push           = 1'b0;
        pop            = 1'b0;
        mispredict     = 1'b0;
        fifo_push      = 1'b0;
        case (state_q)
            RUN: begin
                bus.pred_ready = !reset && !full;
                bus.ex_ready   = !reset && !empty;
                push           = bus.pred_valid && bus.pred_ready;
                pop            = bus.ex_valid && bus.ex_ready;
                mispredict     = pop && miscompare;
                // A push racing a mispredicting resolve is wrong-path: drop it.
                fifo_push      = push && !mispredict;
                if (mispredict) state_d = FLUSH;
            end
            FLUSH:   state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= RUN;
        else       state_q <= state_d;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            bus.upd_valid     <= 1'b0;
            bus.upd_pc        <= '0;
            bus.branch_taken  <= 1'b0;
            bus.branch_target <= '0;
            bus.flush         <= 1'b0;
            bus.redirect_pc   <= '0;
        end else begin
            bus.upd_valid <= pop;
            bus.flush     <= mispredict;
            if (pop) begin
                bus.upd_pc        <= head.pc;
                bus.branch_taken  <= bus.ex_taken;
                bus.branch_target <= bus.ex_target;
            end
            if (mispredict) bus.redirect_pc <= actual_next_pc;
        end
    end

    br_pred_fifo #(
        .DEPTH   (DEPTH),
        .entry_t (br_entry_t)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .clear     (mispredict),
        .push      (fifo_push),
        .push_data (push_entry),
        .pop       (pop),
        .head      (head),
        .full      (full),
        .empty     (empty)
    );

`ifdef BR_STATS_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (pop && (branch_count != '1))
                branch_count <= branch_count + 1'b1;
            if (mispredict && (mispredict_count != '1))
                mispredict_count <= mispredict_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed, table-driven bench for branch_resolver, with hand-written
// sequences for address wrap and reset during FLUSH.
module tb_branch_resolver;
    import br_pkg::*;

    typedef struct {
        bit          pv;
        logic [31:0] pc;
        bit          pr;
        logic [31:0] ppc;
        bit          ev;
        bit          et;
        logic [31:0] etg;
        bit          e_pred_ready;
        bit          e_ex_ready;
        bit          e_upd;
        logic [31:0] e_upd_pc;
        bit          e_taken;
        logic [31:0] e_target;
        bit          e_flush;
        logic [31:0] e_redirect;
    } vec_t;

    logic clk;
    logic reset;
    int   errors;
    int   checks;
    vec_t vecs[$];
    vec_t v;

    branch_resolver_if #(.XLEN(32)) bus ();

`ifdef BR_STATS_EN
    logic [15:0] branch_count;
    logic [15:0] mispredict_count;
`endif

    branch_resolver #(
        .DEPTH (4),
        .XLEN  (32)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
`ifdef BR_STATS_EN
        ,
        .branch_count     (branch_count),
        .mispredict_count (mispredict_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic drive(input bit pv, input logic [31:0] pc, input bit pr,
                         input logic [31:0] ppc, input bit ev, input bit et,
                         input logic [31:0] etg);
        bus.pred_valid   = pv;
        bus.pred_pc      = pc;
        bus.prediction   = pr;
        bus.predicted_pc = ppc;
        bus.ex_valid     = ev;
        bus.ex_taken     = et;
        bus.ex_target    = etg;
    endtask

    function automatic vec_t mk(
        input bit pv, input logic [31:0] pc, input bit pr, input logic [31:0] ppc,
        input bit ev, input bit et, input logic [31:0] etg,
        input bit epr, input bit eer,
        input bit eupd, input logic [31:0] eupc, input bit etk, input logic [31:0] etgt,
        input bit efl, input logic [31:0] erd);
        vec_t r;
        r.pv = pv; r.pc = pc; r.pr = pr; r.ppc = ppc;
        r.ev = ev; r.et = et; r.etg = etg;
        r.e_pred_ready = epr; r.e_ex_ready = eer;
        r.e_upd = eupd; r.e_upd_pc = eupc; r.e_taken = etk; r.e_target = etgt;
        r.e_flush = efl; r.e_redirect = erd;
        return r;
    endfunction

    initial begin
        errors = 0;
        checks = 0;

        //            pv pc        pr ppc       ev et etg       rdy  upd pc     tk tgt      fl rd
        // mispredicted not-taken, then push refused during FLUSH
        vecs.push_back(mk(1, 'h1000, 0, 'h1004, 0, 0, 'h0,    1, 0, 0, 'h0,    0, 'h0,    0, 'h0));
        vecs.push_back(mk(0, 'h0,    0, 'h0,    1, 1, 'h1040, 1, 1, 1, 'h1000, 1, 'h1040, 1, 'h1040));
        vecs.push_back(mk(1, 'h3000, 0, 'h3004, 0, 0, 'h0,    0, 0, 0, 'h0,    0, 'h0,    0, 'h0));
        vecs.push_back(mk(0, 'h0,    0, 'h0,    0, 0, 'h0,    1, 0, 0, 'h0,    0, 'h0,    0, 'h0));
        // correct taken prediction
        vecs.push_back(mk(1, 'h1000, 1, 'h1040, 0, 0, 'h0,    1, 0, 0, 'h0,    0, 'h0,    0, 'h0));
        vecs.push_back(mk(0, 'h0,    0, 'h0,    1, 1, 'h1040, 1, 1, 1, 'h1000, 1, 'h1040, 0, 'h0));
        vecs.push_back(mk(0, 'h0,    0, 'h0,    0, 0, 'h0,    1, 0, 0, 'h0,    0, 'h0,    0, 'h0));
        // fill to 4
        vecs.push_back(mk(1, 'h100,  0, 'h0,    0, 0, 'h0,    1, 0, 0, 'h0,    0, 'h0,    0, 'h0));
        vecs.push_back(mk(1, 'h104,  0, 'h0,    0, 0, 'h0,    1, 1, 0, 'h0,    0, 'h0,    0, 'h0));
        vecs.push_back(mk(1, 'h108,  0, 'h0,    0, 0, 'h0,    1, 1, 0, 'h0,    0, 'h0,    0, 'h0));
        vecs.push_back(mk(1, 'h10C,  0, 'h0,    0, 0, 'h0,    1, 1, 0, 'h0,    0, 'h0,    0, 'h0));
        vecs.push_back(mk(0, 'h0,    0, 'h0,    0, 0, 'h0,    0, 1, 0, 'h0,    0, 'h0,    0, 'h0));
        // full: push with simultaneous pop is refused
        vecs.push_back(mk(1, 'h200,  0, 'h0,    1, 0, 'h5555, 0, 1, 1, 'h100,  0, 'h5555, 0, 'h0));
        vecs.push_back(mk(0, 'h0,    0, 'h0,    0, 0, 'h0,    1, 1, 0, 'h0,    0, 'h0,    0, 'h0));
        // push+pop at 3 entries
        vecs.push_back(mk(1, 'h110,  0, 'h0,    1, 0, 'h0,    1, 1, 1, 'h104,  0, 'h0,    0, 'h0));
        vecs.push_back(mk(0, 'h0,    0, 'h0,    0, 0, 'h0,    1, 1, 0, 'h0,    0, 'h0,    0, 'h0));
        vecs.push_back(mk(0, 'h0,    0, 'h0,    1, 0, 'h0,    1, 1, 1, 'h108,  0, 'h0,    0, 'h0));
        vecs.push_back(mk(0, 'h0,    0, 'h0,    1, 0, 'h0,    1, 1, 1, 'h10C,  0, 'h0,    0, 'h0));
        vecs.push_back(mk(0, 'h0,    0, 'h0,    1, 0, 'h0,    1, 1, 1, 'h110,  0, 'h0,    0, 'h0));
        vecs.push_back(mk(0, 'h0,    0, 'h0,    0, 0, 'h0,    1, 0, 0, 'h0,    0, 'h0,    0, 'h0));
        // three queued, oldest wrong target; racing push dropped
        vecs.push_back(mk(1, 'h1F00, 1, 'h2000, 0, 0, 'h0,    1, 0, 0, 'h0,    0, 'h0,    0, 'h0));
        vecs.push_back(mk(1, 'h1F04, 0, 'h0,    0, 0, 'h0,    1, 1, 0, 'h0,    0, 'h0,    0, 'h0));
        vecs.push_back(mk(1, 'h1F08, 0, 'h0,    0, 0, 'h0,    1, 1, 0, 'h0,    0, 'h0,    0, 'h0));
        vecs.push_back(mk(1, 'h3333, 0, 'h0,    1, 1, 'h2080, 1, 1, 1, 'h1F00, 1, 'h2080, 1, 'h2080));
        vecs.push_back(mk(0, 'h0,    0, 'h0,    0, 0, 'h0,    0, 0, 0, 'h0,    0, 'h0,    0, 'h0));
        vecs.push_back(mk(0, 'h0,    0, 'h0,    0, 0, 'h0,    1, 0, 0, 'h0,    0, 'h0,    0, 'h0));

        // Reset and idle state
        reset = 1'b1;
        drive(0, '0, 0, '0, 0, 0, '0);
        repeat (10) @(posedge clk);
        #1;
        reset = 1'b0;
        #1;
        chk("rst upd_valid",     bus.upd_valid,     0);
        chk("rst upd_pc",        bus.upd_pc,        0);
        chk("rst branch_taken",  bus.branch_taken,  0);
        chk("rst branch_target", bus.branch_target, 0);
        chk("rst flush",         bus.flush,         0);
        chk("rst redirect_pc",   bus.redirect_pc,   0);
        chk("rst pred_ready",    bus.pred_ready,    1);
        chk("rst ex_ready",      bus.ex_ready,      0);
`ifdef BR_STATS_EN
        chk("rst branch_count",     branch_count,     0);
        chk("rst mispredict_count", mispredict_count, 0);
`endif

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v.pv, v.pc, v.pr, v.ppc, v.ev, v.et, v.etg);
            #1;
            chk($sformatf("v%0d pred_ready", i), bus.pred_ready, v.e_pred_ready);
            chk($sformatf("v%0d ex_ready", i),   bus.ex_ready,   v.e_ex_ready);
            @(posedge clk);
            #1;
            chk($sformatf("v%0d upd_valid", i), bus.upd_valid, v.e_upd);
            chk($sformatf("v%0d flush", i),     bus.flush,     v.e_flush);
            if (v.e_upd) begin
                chk($sformatf("v%0d upd_pc", i),        bus.upd_pc,        v.e_upd_pc);
                chk($sformatf("v%0d branch_taken", i),  bus.branch_taken,  v.e_taken);
                chk($sformatf("v%0d branch_target", i), bus.branch_target, v.e_target);
            end
            if (v.e_flush)
                chk($sformatf("v%0d redirect_pc", i), bus.redirect_pc, v.e_redirect);
        end

`ifdef BR_STATS_EN
        chk("stats branch_count",     branch_count,     8);
        chk("stats mispredict_count", mispredict_count, 2);
`endif

        // PC wrap on fall-through, then reset during the FLUSH cycle
        drive(1, 32'hFFFF_FFFC, 1, 32'h0000_0100, 0, 0, '0);
        @(posedge clk);
        #1;
        drive(0, '0, 0, '0, 1, 0, 32'h0000_1234);
        #1;
        chk("wrap ex_ready", bus.ex_ready, 1);
        @(posedge clk);
        #1;
        drive(0, '0, 0, '0, 0, 0, '0);
        chk("wrap flush",         bus.flush,         1);
        chk("wrap redirect_pc",   bus.redirect_pc,   32'h0000_0000);
        chk("wrap upd_valid",     bus.upd_valid,     1);
        chk("wrap upd_pc",        bus.upd_pc,        32'hFFFF_FFFC);
        chk("wrap branch_taken",  bus.branch_taken,  0);
        chk("wrap branch_target", bus.branch_target, 32'h0000_1234);
        reset = 1'b1;
        #1;
        chk("flushrst pred_ready held", bus.pred_ready, 0);
        @(posedge clk);
        #1;
        chk("flushrst flush",     bus.flush,     0);
        chk("flushrst upd_valid", bus.upd_valid, 0);
`ifdef BR_STATS_EN
        chk("flushrst branch_count",     branch_count,     0);
        chk("flushrst mispredict_count", mispredict_count, 0);
`endif
        reset = 1'b0;
        #1;
        chk("flushrst pred_ready", bus.pred_ready, 1);
        chk("flushrst ex_ready",   bus.ex_ready,   0);
        @(posedge clk);
        #1;
        chk("flushrst flush idle", bus.flush, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/branch_resolver.md
# branch_resolver

Execute-stage counterpart to `branch_predictor`. It queues each prediction issued at fetch and checks it against the real branch outcome from execute. It then sends the training update (`branch_taken`/`branch_target`) back to the predictor. On a misprediction it raises a one-cycle pipeline flush with the corrected fetch PC.

## Interface
Parameters:
- `DEPTH`, 4: in-flight prediction queue entries (power of two, ≥2).
- `XLEN`, 32: PC/target width.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `pred_valid` in 1: fetch pushes one predicted branch.
- `pred_pc` in XLEN: PC of the branch.
- `prediction` in 1: predicted taken (1) or not-taken (0).
- `predicted_pc` in XLEN: predicted next PC.
- `pred_ready` out 1: push accepted this cycle.
- `ex_valid` in 1: execute resolves the oldest queued branch.
- `ex_taken` in 1: actual direction.
- `ex_target` in XLEN: actual taken target.
- `ex_ready` out 1: resolve accepted this cycle.
- `upd_valid` out 1: one-cycle predictor-training pulse.
- `upd_pc` out XLEN: PC being trained.
- `branch_taken` out 1: actual direction, to the predictor.
- `branch_target` out XLEN: actual target, to the predictor.
- `flush` out 1: one-cycle flush of wrong-path instructions.
- `redirect_pc` out XLEN: corrected fetch PC, valid while `flush`=1.

## Operation
- Queue: FIFO of {pred_pc, prediction, predicted_pc}.
  - Push on `pred_valid && pred_ready`.
  - Pop on `ex_valid && ex_ready`.
  - In-order only.
- `pred_ready` = !reset && state==RUN && !full.
- `ex_ready` = !reset && state==RUN && !empty.
- Push and pop in the same cycle are both accepted, and occupancy is unchanged. A full queue never accepts a push, even with a simultaneous pop.
- Actual next PC = `ex_taken` ? `ex_target` : `pred_pc`+4, computed modulo 2^XLEN (wraps).
- Mispredict = (`prediction` != `ex_taken`) || (`prediction` && `ex_taken` && `predicted_pc` != `ex_target`). A correct not-taken prediction ignores `predicted_pc`.
- Every resolve drives `upd_valid`=1 for one cycle, with `upd_pc`=entry pc, `branch_taken`=`ex_taken` and `branch_target`=`ex_target`.
- FSM states:
  - RUN: accepts pushes and resolves. A mispredicting resolve moves to FLUSH.
  - FLUSH: lasts one cycle; `flush`=1 and `redirect_pc`=actual next PC. The queue is cleared on entry. No push or resolve is accepted. Always returns to RUN.
- Wrong-path data:
  - A push in the same cycle as a mispredicting resolve is dropped.
  - All younger entries are discarded.

## Timing
- All outputs except `pred_ready`/`ex_ready` are registered. Reset value of every registered output is 0. After reset the queue is empty and the state is RUN.
- Resolve handshake in cycle N produces `upd_*` in cycle N+1.
- On mispredict, `flush` and `redirect_pc` are also asserted in N+1, and the state is FLUSH in N+1. First new push is possible in N+2.
- Reset during FLUSH: the next cycle has `flush`=0, the queue empty and the state RUN; the pending update is lost.
- `upd_valid`/`flush` never stay high for two consecutive cycles from one resolve.

## Configuration
- `BR_STATS_EN` defined:
  - Adds outputs `branch_count` and `mispredict_count`, each 16 bits.
  - Each increments in the cycle its event registers (N+1) and saturates at 16'hFFFF.
  - Both clear on reset.
- Undefined: the ports and counters do not exist; behaviour is otherwise identical.

## Structure
- `br_pkg`: FSM state enum (RUN, FLUSH), queue entry struct typedef, `INSTR_BYTES`=4 constant.
- One sub-module, `br_pred_fifo`: parameterised synchronous FIFO with clear input and full/empty flags. The top-level module holds the compare, the FSM and the registered outputs.

## Test plan
- Reset held 10 cycles, then released → all registered outputs 0, `pred_ready`=1, `ex_ready`=0.
- Push pc 0x1000, pred=0, ppc 0x1004; resolve taken, target 0x1040 → next cycle `upd_valid`=1, `upd_pc`=0x1000, `branch_taken`=1, `branch_target`=0x1040, `flush`=1, `redirect_pc`=0x1040, `pred_ready`=0; one cycle later `flush`=0, `pred_ready`=1.
- Push pc 0x1000, pred=1, ppc 0x1040; resolve taken, target 0x1040 → `upd_valid` pulse, `flush` stays 0.
- Push 4 entries → `pred_ready`=0; one resolve (correct) → `pred_ready`=1 next cycle; a simultaneous push and pop at 3 entries holds occupancy at 3.
- Three entries queued, oldest pred=1, ppc 0x2000, actual taken 0x2080 → `flush`=1, `redirect_pc`=0x2080, queue empty (`ex_ready`=0 after FLUSH); with `BR_STATS_EN`, `mispredict_count` increments by 1.
- Push pc 0xFFFFFFFC, pred=1; resolve not-taken → `redirect_pc`=0x00000000; reset asserted during the FLUSH cycle → next cycle `flush`=0 and the queue is empty.
